// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data memory: access sizes, FSM state
// codes and the wait-state counter width.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_CLR  = 2'd0;
  localparam state_t ST_IDLE = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and the data
// memory controller (slave).
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 10
);

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [1:0]        req_size;
  logic              req_sign;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_size, req_sign,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_size, req_sign,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store byte-enables plus merged write word, and
// sign/zero-extended load result. Low offset bits are forced to natural alignment.
module mem_lane_align
  import mem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wmerged,
  output logic [31:0] rdata
);

  logic [1:0]  lane_s;
  logic [31:0] wlane_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the starting lane, enables and replicated store data per size
  always_comb begin
    lane_s  = 2'b00;
    be      = 4'b0000;
    wlane_s = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        lane_s  = offset;
        be      = 4'b0001 << offset;
        wlane_s = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        lane_s  = {offset[1], 1'b0};
        be      = offset[1] ? 4'b1100 : 4'b0011;
        wlane_s = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        lane_s  = 2'b00;
        be      = 4'b1111;
        wlane_s = wdata;
      end
      default: begin
        lane_s  = 2'b00;
        be      = 4'b0000;
        wlane_s = 32'h0000_0000;
      end
    endcase
  end

  // Read-modify-write merge: unselected lanes keep the stored bytes
  always_comb begin
    wmerged = rword;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        wmerged[8*i +: 8] = wlane_s[8*i +: 8];
      end else begin
        wmerged[8*i +: 8] = rword[8*i +: 8];
      end
    end
  end

  // Extract the addressed byte/half and extend it
  always_comb begin
    case (lane_s)
      2'd0:    byte_s = rword[7:0];
      2'd1:    byte_s = rword[15:8];
      2'd2:    byte_s = rword[23:16];
      2'd3:    byte_s = rword[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = lane_s[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_BYTE: rdata = {{24{sign & byte_s[7]}}, byte_s};
      SZ_HALF: rdata = {{16{sign & half_s[15]}}, half_s};
      SZ_WORD: rdata = rword;
      default: rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed 32-bit data memory with wait-state handshake and a
// post-reset clear sweep. Define MISALIGN_TRAP_EN to fault misaligned half/word.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input logic            clk,
  input logic            rst,
  data_mem_ctrl_if.slave bus
);

  localparam int                DEPTH     = 2 ** (ADDR_W - 2);
  localparam int                IDX_W     = ADDR_W - 2;
  localparam logic [IDX_W-1:0]  LAST_IDX  = '1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

  logic [31:0] mem_r [DEPTH];

  state_t            state_r;
  logic [IDX_W-1:0]  clr_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              wr_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  size_e             size_r;
  logic              sign_r;
  logic              ready_r;
  logic              rsp_valid_r;
  logic [31:0]       rsp_rdata_r;
  logic              rsp_err_r;

  logic [31:0]       rword_s;
  logic [3:0]        be_s;
  logic [31:0]       wmerged_s;
  logic [31:0]       ldata_s;
  logic              err_s;
  logic              access_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  mem_widx_s;
  logic [31:0]       mem_wdata_s;

  assign bus.req_ready = ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;

  assign rword_s  = mem_r[addr_r[ADDR_W-1:2]];
  assign access_s = (state_r == ST_WAIT) && (wait_cnt_r == '0);

  mem_lane_align u_align (
    .size    (size_r),
    .offset  (addr_r[1:0]),
    .sign    (sign_r),
    .wdata   (wdata_r),
    .rword   (rword_s),
    .be      (be_s),
    .wmerged (wmerged_s),
    .rdata   (ldata_s)
  );

  // Fault classification of the latched request
  always_comb begin
`ifdef MISALIGN_TRAP_EN
    err_s = (size_r == SZ_RSVD)
         || ((size_r == SZ_HALF) && addr_r[0])
         || ((size_r == SZ_WORD) && (addr_r[1:0] != 2'b00));
`else
    err_s = (size_r == SZ_RSVD);
`endif
  end

  // Single write port shared by the clear sweep and committed stores
  always_comb begin
    mem_we_s    = 1'b0;
    mem_widx_s  = clr_cnt_r;
    mem_wdata_s = 32'h0000_0000;
    if (!rst) begin
      mem_we_s = 1'b0;
    end else if (state_r == ST_CLR) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = clr_cnt_r;
      mem_wdata_s = 32'h0000_0000;
    end else if (access_s && wr_r && !err_s && (be_s != 4'b0000)) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = addr_r[ADDR_W-1:2];
      mem_wdata_s = wmerged_s;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Storage array (contents are cleared by the CLR sweep, not by reset)
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_widx_s] <= mem_wdata_s;
    end
  end

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_CLR;
      clr_cnt_r   <= '0;
      wait_cnt_r  <= '0;
      wr_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= 32'h0000_0000;
      size_r      <= SZ_BYTE;
      sign_r      <= 1'b0;
      ready_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_CLR: begin
          clr_cnt_r <= clr_cnt_r + IDX_W'(1);
          if (clr_cnt_r == LAST_IDX) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.req_valid) begin
            wr_r       <= bus.req_wr;
            addr_r     <= bus.req_addr;
            wdata_r    <= bus.req_wdata;
            size_r     <= size_e'(bus.req_size);
            sign_r     <= bus.req_sign;
            wait_cnt_r <= WAIT_INIT;
            ready_r    <= 1'b0;
            state_r    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r != '0) begin
            wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
          end else begin
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= err_s;
            rsp_rdata_r <= (wr_r || err_s) ? 32'h0000_0000 : ldata_s;
          end
        end
        ST_RESP: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= 32'h0000_0000;
          rsp_err_r   <= 1'b0;
          ready_r     <= 1'b1;
        end
        default: begin
          state_r   <= ST_CLR;
          clr_cnt_r <= '0;
          ready_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: byte-array reference model, directed
// test-plan cases, mid-operation reset and randomized traffic.
module tb_data_mem_ctrl;

  localparam int AW    = 10;
  localparam int WC    = 3;
  localparam int DEPTH = 2 ** (AW - 2);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(AW)) bus ();

  data_mem_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem_m [1 << AW];
  int         checks = 0;
  int         errors = 0;
  int         ncyc   = 0;
  bit         mon_en = 1'b0;

  // Reference behaviour: byte-array memory, little-endian, natural alignment
  function automatic void model(input logic wr, input logic [AW-1:0] addr,
                                input logic [31:0] wd, input logic [1:0] sz,
                                input logic sg, output logic [31:0] rdata,
                                output logic err);
    int          nb;
    int          a;
    logic [63:0] v;
    rdata = 32'h0;
    err   = 1'b0;
    if (sz == 2'd3) begin
      err = 1'b1;
      return;
    end
    nb = 1 << sz;
`ifdef MISALIGN_TRAP_EN
    if ((int'(addr) % nb) != 0) begin
      err = 1'b1;
      return;
    end
`endif
    a = int'(addr) - (int'(addr) % nb);
    if (wr) begin
      for (int i = 0; i < nb; i++) mem_m[a + i] = wd[8*i +: 8];
    end else begin
      v = 64'h0;
      for (int i = 0; i < nb; i++) v = v | (64'(mem_m[a + i]) << (8 * i));
      if (sg && v[8*nb-1]) v = v | (~64'h0 << (8 * nb));
      rdata = v[31:0];
    end
  endfunction

  // Monitor: pops the scoreboard on every response, checks quiet outputs otherwise
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (mon_en) begin
      if (bus.rsp_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp cycle=%0d rdata=%h err=%b", ncyc, bus.rsp_rdata, bus.rsp_err);
        end else begin
          e = exp_q.pop_front();
          if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
            errors++;
            $display("FAIL rsp_data got rdata=%h err=%b expected rdata=%h err=%b",
                     bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
          end
          checks++;
          if (ncyc != e.cyc) begin
            errors++;
            $display("FAIL rsp_latency got cycle %0d expected %0d", ncyc, e.cyc);
          end
          checks++;
          if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_resp got %b expected 0", bus.req_ready);
          end
        end
      end else begin
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs got valid=%b rdata=%h err=%b expected 0/0/0",
                   bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
      end
    end
  end

  task automatic do_reset();
    int n;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b valid=%b rdata=%h err=%b expected all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = 8'h00;
    mon_en = 1'b1;
    rst = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL clear_cycles got %0d expected %0d", n, DEPTH);
    end
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sg);
    int   n;
    exp_t e;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 500) begin
      n++;
      @(negedge clk);
      #1;
    end
    if (bus.req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got ready=%b expected 1", bus.req_ready);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_size  = sz;
    bus.req_sign  = sg;
    model(wr, addr, wd, sz, sg, e.rdata, e.err);
    e.cyc = ncyc + WC + 2;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    bus.req_valid = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_accept got %b expected 0", bus.req_ready);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_resp got %b expected 1", bus.req_ready);
    end
  endtask

  initial begin
    logic [AW-1:0] ra;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = 32'h0;
    bus.req_size  = 2'd0;
    bus.req_sign  = 1'b0;

    do_reset();
    issue(1'b0, 10'h3FC, 32'h0, 2'd2, 1'b0); drain();
    issue(1'b1, 10'h004, 32'h1234ABCD, 2'd2, 1'b0); drain();
    issue(1'b0, 10'h005, 32'h0, 2'd0, 1'b1); drain();
    issue(1'b0, 10'h005, 32'h0, 2'd0, 1'b0); drain();
    issue(1'b0, 10'h006, 32'h0, 2'd1, 1'b1); drain();
    issue(1'b1, 10'h007, 32'h0000007F, 2'd0, 1'b0); drain();
    issue(1'b0, 10'h004, 32'h0, 2'd2, 1'b0); drain();
    issue(1'b0, 10'h006, 32'h0, 2'd2, 1'b0); drain();
    issue(1'b1, 10'h009, 32'hFFFF8001, 2'd1, 1'b0); drain();
    issue(1'b0, 10'h008, 32'h0, 2'd1, 1'b1); drain();
    issue(1'b1, 10'h00C, 32'hFFFFFFFF, 2'd3, 1'b0); drain();
    issue(1'b0, 10'h004, 32'h0, 2'd3, 1'b1); drain();
    issue(1'b0, 10'h00C, 32'h0, 2'd2, 1'b0); drain();

    issue(1'b1, 10'h010, 32'hDEADBEEF, 2'd2, 1'b0);
    do_reset();
    issue(1'b0, 10'h010, 32'h0, 2'd2, 1'b0); drain();

    for (int k = 0; k < 300; k++) begin
      ra = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) ra = AW'($urandom_range(0, (1 << AW) - 1));
      issue(1'($urandom_range(0, 1)), ra, $urandom, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
